ir_code_mem_arb: RTL and testbench
==================================

// Module: ir_code_mem_arb
// PURPOSE
//  Parametrised, multi-bank IR code memory with port ownership arbitration between the host
//  register interface and the IR Tx/Rx engine. Replaces the fixed two-bank memory glue in the
//  IR wrapper. Adds:
//   - N banks
//   - a registered, tagged 2-cycle read pipeline with valid strobes
//   - sticky host-collision error reporting
//  Sits between the register interface (host side) and the IR Tx/Rx engine (IR side).
// PARAMETERS
//  ADR_WIDTH       11  total code address width; upper ADR_WIDTH-BANK_ADR_WIDTH bits select the bank
//  BANK_ADR_WIDTH  10  per-bank address width (bank depth = 2**BANK_ADR_WIDTH)
//  DAT_WIDTH       8   code word width
//  NUM_BANKS       localparam = 2**(ADR_WIDTH-BANK_ADR_WIDTH); ADR_WIDTH>=BANK_ADR_WIDTH is required
// PORTS
//  CLK_i           in   1          single clock for all logic and memories
//  RST_i           in   1          asynchronous, active-high reset
//  MODE_i          in   1          0 = Tx, 1 = Rx
//  BUSY_i          in   1          engine busy; ownership = f(MODE_i, BUSY_i)
//  HOST_WE_i       in   1          host write strobe
//  HOST_RE_i       in   1          host read strobe
//  HOST_ADR_i      in   ADR_WIDTH  host address
//  HOST_WD_i       in   DAT_WIDTH  host write data
//  HOST_RD_o       out  DAT_WIDTH  host read data (held until next host read completes)
//  HOST_RD_VLD_o   out  1          1-cycle pulse: HOST_RD_o updated
//  HOST_ERR_o      out  1          sticky: host access dropped due to engine ownership
//  HOST_ERR_CLR_i  in   1          clears HOST_ERR_o
//  IR_WE_i         in   1          engine write strobe (Rx capture)
//  IR_RE_i         in   1          engine read strobe (Tx playback)
//  IR_ADR_i        in   ADR_WIDTH  engine address
//  IR_WD_i         in   DAT_WIDTH  engine write data
//  IR_RD_o         out  DAT_WIDTH  engine read data (held)
//  IR_RD_VLD_o     out  1          1-cycle pulse: IR_RD_o updated
// BEHAVIOUR
//  Ownership
//   - TX_ON = ~MODE_i & BUSY_i; RX_ON = MODE_i & BUSY_i.
//   - Write port owner: IR if RX_ON, else host. Read port owner: IR if TX_ON, else host.
//   - Host WE while RX_ON, or host RE while TX_ON: access dropped, HOST_ERR_o set next cycle.
//   - IR WE without RX_ON, or IR RE without TX_ON: silently ignored, no error.
//  Write
//   - Owner's WE writes WD into bank ADR[ADR_WIDTH-1:BANK_ADR_WIDTH] at word ADR[BANK_ADR_WIDTH-1:0]
//     on that clock edge. Only the addressed bank is enabled.
//  Read (latency 2)
//   - Cycle 0: owner RE accepted; bank index and owner tag (host/IR) registered; all banks read.
//   - Cycle 1: registered bank data muxed by the registered bank index.
//   - Cycle 2: result registered into the tagged port's RD_o, with its VLD_o pulsing for 1 cycle.
//     The other port's RD_o is unchanged.
//   - Fully pipelined: back-to-back REs give one result per cycle.
//  Boundary cases
//   - Same-address read and write in the same cycle: read-first (returns old data).
//   - Ownership change while a read is in flight: the result is delivered to the port that issued
//     it (owner tag).
//   - HOST_ERR set and HOST_ERR_CLR_i in the same cycle: set wins.
//   - Last bank, top word, wrap: ADR is plain binary; no wrap logic here (the engine owns
//     address sequencing).
//   - Reset (any time, including mid-read): HOST_RD_o = 0, IR_RD_o = 0, both VLD = 0,
//     HOST_ERR_o = 0, pipeline tags cleared, in-flight reads discarded. Memory contents are
//     not reset.
// STRUCTURE
//  - Package ir_pkg: IR_MODE_TX = 1'b0, IR_MODE_RX = 1'b1, OWN_HOST = 1'b0, OWN_IR = 1'b1.
//  - Sub-module ir_code_mem_bank (params BANK_ADR_WIDTH, DAT_WIDTH):
//    - simple dual-port RAM with registered read-first output
//    - ports CLK_i, WE_i, WA_i, WD_i, RE_i, RA_i, RD_o
//    - read output holds when RE_i = 0
//    - instantiated NUM_BANKS times in a generate loop
//  - Top level holds only the ownership muxes, the error flag, and the 2-stage read pipeline.
// TESTING
//  1. Idle (BUSY = 0): host writes 0xA5 @ 0x005 and 0x3C @ 0x405, then reads 0x405, 0x005
//     back-to-back -> HOST_RD_VLD pulses cycles 2 and 3 with 0x3C, 0xA5; HOST_ERR = 0.
//  2. MODE = 0, BUSY = 1: IR reads 0x405 -> IR_RD = 0x3C at +2, HOST_RD unchanged.
//     Host RE @ 0x005 in the same state -> dropped, HOST_ERR = 1.
//     HOST_ERR_CLR pulse -> 0.
//  3. MODE = 1, BUSY = 1: IR writes 0x77 @ 0x7FF; host write @ 0x7FF -> ignored, HOST_ERR = 1.
//     After BUSY = 0, host read 0x7FF -> 0x77.
//  4. Host RE @ 0x005 issued, BUSY -> 1 (Tx) the next cycle -> result still lands on HOST_RD with
//     HOST_RD_VLD; IR_RD_VLD stays 0.
//  5. Same-cycle IR write 0x11 and host read @ 0x010 (Rx) -> host gets old value, a later read
//     gets 0x11. Asserting RST_i 1 cycle after an RE -> no VLD pulse, all outputs 0.
//  6. Re-run 1-3 with ADR_WIDTH = 12, BANK_ADR_WIDTH = 9 (8 banks): write a unique value to each
//     bank's word 0 -> reads return the matching values.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared encodings for the IR code memory: engine mode and read-port owner tags.
package ir_pkg;

    localparam logic IR_MODE_TX = 1'b0;
    localparam logic IR_MODE_RX = 1'b1;

    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_IR   = 1'b1;

endpackage

// File: rtl/ir_code_mem_bank.sv
// One bank of IR code memory: simple dual-port RAM with a registered, read-first output.
// Read latency 1; the output register holds its value while RE_i is low.
module ir_code_mem_bank #(
    parameter int BANK_ADR_WIDTH = 10,
    parameter int DAT_WIDTH      = 8
) (
    input  logic                      CLK_i,
    input  logic                      WE_i,
    input  logic [BANK_ADR_WIDTH-1:0] WA_i,
    input  logic [DAT_WIDTH-1:0]      WD_i,
    input  logic                      RE_i,
    input  logic [BANK_ADR_WIDTH-1:0] RA_i,
    output logic [DAT_WIDTH-1:0]      RD_o
);

    logic [DAT_WIDTH-1:0] r_mem [2**BANK_ADR_WIDTH];
    logic [DAT_WIDTH-1:0] r_rd;

    // Write and read sample the array on the same edge, so a same-address read returns old data.
    always_ff @(posedge CLK_i) begin
        if (WE_i) begin
            r_mem[WA_i] <= WD_i;
        end
        if (RE_i) begin
            r_rd <= r_mem[RA_i];
        end
    end

    assign RD_o = r_rd;

endmodule

// File: rtl/ir_code_mem_arb.sv
// Multi-bank IR code memory shared by host and IR engine; ownership follows MODE_i/BUSY_i.
// Read latency 2, fully pipelined; no backpressure, host accesses on an engine-owned port are dropped and flagged.
module ir_code_mem_arb
    import ir_pkg::*;
#(
    parameter int ADR_WIDTH      = 11,
    parameter int BANK_ADR_WIDTH = 10,
    parameter int DAT_WIDTH      = 8
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    input  logic                 MODE_i,
    input  logic                 BUSY_i,
    input  logic                 HOST_WE_i,
    input  logic                 HOST_RE_i,
    input  logic [ADR_WIDTH-1:0] HOST_ADR_i,
    input  logic [DAT_WIDTH-1:0] HOST_WD_i,
    output logic [DAT_WIDTH-1:0] HOST_RD_o,
    output logic                 HOST_RD_VLD_o,
    output logic                 HOST_ERR_o,
    input  logic                 HOST_ERR_CLR_i,
    input  logic                 IR_WE_i,
    input  logic                 IR_RE_i,
    input  logic [ADR_WIDTH-1:0] IR_ADR_i,
    input  logic [DAT_WIDTH-1:0] IR_WD_i,
    output logic [DAT_WIDTH-1:0] IR_RD_o,
    output logic                 IR_RD_VLD_o
);

    localparam int NUM_BANKS = 2**(ADR_WIDTH-BANK_ADR_WIDTH);
    // A single-bank build still needs a 1-bit select so the index signals stay legal.
    localparam int BSEL_W = (ADR_WIDTH > BANK_ADR_WIDTH) ? (ADR_WIDTH - BANK_ADR_WIDTH) : 1;

    logic                 w_tx_on;
    logic                 w_rx_on;
    logic                 w_we;
    logic                 w_re;
    logic                 w_re_tag;
    logic                 w_err_set;
    logic [ADR_WIDTH-1:0] w_wa;
    logic [ADR_WIDTH-1:0] w_ra;
    logic [DAT_WIDTH-1:0] w_wd;
    logic [DAT_WIDTH-1:0] w_mux;
    logic [BSEL_W-1:0]    w_wbank;
    logic [BSEL_W-1:0]    w_rbank;
    logic [DAT_WIDTH-1:0] w_bank_rd [NUM_BANKS];

    logic                 r_s1_vld;
    logic                 r_s1_tag;
    logic [BSEL_W-1:0]    r_s1_bank;
    logic [DAT_WIDTH-1:0] r_host_rd;
    logic [DAT_WIDTH-1:0] r_ir_rd;
    logic                 r_host_vld;
    logic                 r_ir_vld;
    logic                 r_err;

    assign w_tx_on = (MODE_i == IR_MODE_TX) && BUSY_i;
    assign w_rx_on = (MODE_i == IR_MODE_RX) && BUSY_i;

    assign w_we = w_rx_on ? IR_WE_i  : HOST_WE_i;
    assign w_wa = w_rx_on ? IR_ADR_i : HOST_ADR_i;
    assign w_wd = w_rx_on ? IR_WD_i  : HOST_WD_i;

    assign w_re     = w_tx_on ? IR_RE_i  : HOST_RE_i;
    assign w_ra     = w_tx_on ? IR_ADR_i : HOST_ADR_i;
    assign w_re_tag = w_tx_on ? OWN_IR   : OWN_HOST;

    assign w_err_set = (HOST_WE_i && w_rx_on) || (HOST_RE_i && w_tx_on);

    assign w_wbank = BSEL_W'(w_wa >> BANK_ADR_WIDTH);
    assign w_rbank = BSEL_W'(w_ra >> BANK_ADR_WIDTH);

    // Every bank reads on an accepted RE; the registered bank index picks the result a cycle later.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ir_code_mem_bank #(
            .BANK_ADR_WIDTH (BANK_ADR_WIDTH),
            .DAT_WIDTH      (DAT_WIDTH)
        ) u_bank (
            .CLK_i (CLK_i),
            .WE_i  (w_we && (w_wbank == BSEL_W'(g))),
            .WA_i  (w_wa[BANK_ADR_WIDTH-1:0]),
            .WD_i  (w_wd),
            .RE_i  (w_re),
            .RA_i  (w_ra[BANK_ADR_WIDTH-1:0]),
            .RD_o  (w_bank_rd[g])
        );
    end

    assign w_mux = w_bank_rd[r_s1_bank];

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_s1_vld   <= 1'b0;
            r_s1_tag   <= OWN_HOST;
            r_s1_bank  <= '0;
            r_host_rd  <= '0;
            r_ir_rd    <= '0;
            r_host_vld <= 1'b0;
            r_ir_vld   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_vld <= w_re;
            r_s1_tag <= w_re_tag;
            if (w_re) begin
                r_s1_bank <= w_rbank;
            end

            // The tag captured at issue steers the result, whatever the ownership is now.
            r_host_vld <= r_s1_vld && (r_s1_tag == OWN_HOST);
            r_ir_vld   <= r_s1_vld && (r_s1_tag == OWN_IR);
            if (r_s1_vld && (r_s1_tag == OWN_HOST)) begin
                r_host_rd <= w_mux;
            end
            if (r_s1_vld && (r_s1_tag == OWN_IR)) begin
                r_ir_rd <= w_mux;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (HOST_ERR_CLR_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign HOST_RD_o     = r_host_rd;
    assign HOST_RD_VLD_o = r_host_vld;
    assign HOST_ERR_o    = r_err;
    assign IR_RD_o       = r_ir_rd;
    assign IR_RD_VLD_o   = r_ir_vld;

endmodule

// File: tb/tb_ir_code_mem_arb.sv
// Directed bench for ir_code_mem_arb: default 2-bank build plus an 8-bank build.
module tb_ir_code_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Instance A: ADR_WIDTH 11, BANK_ADR_WIDTH 10
    logic        mode, busy, h_we, h_re, h_clr, i_we, i_re;
    logic [10:0] h_adr, i_adr;
    logic [7:0]  h_wd, i_wd, h_rd, i_rd;
    logic        h_vld, h_err, i_vld;

    // Instance B: ADR_WIDTH 12, BANK_ADR_WIDTH 9
    logic        b_mode, b_busy, b_h_we, b_h_re, b_h_clr, b_i_we, b_i_re;
    logic [11:0] b_h_adr, b_i_adr;
    logic [7:0]  b_h_wd, b_i_wd, b_h_rd, b_i_rd;
    logic        b_h_vld, b_h_err, b_i_vld;

    always #5 clk = ~clk;

    ir_code_mem_arb #(.ADR_WIDTH(11), .BANK_ADR_WIDTH(10), .DAT_WIDTH(8)) u_dut_a (
        .CLK_i(clk), .RST_i(rst), .MODE_i(mode), .BUSY_i(busy),
        .HOST_WE_i(h_we), .HOST_RE_i(h_re), .HOST_ADR_i(h_adr), .HOST_WD_i(h_wd),
        .HOST_RD_o(h_rd), .HOST_RD_VLD_o(h_vld), .HOST_ERR_o(h_err), .HOST_ERR_CLR_i(h_clr),
        .IR_WE_i(i_we), .IR_RE_i(i_re), .IR_ADR_i(i_adr), .IR_WD_i(i_wd),
        .IR_RD_o(i_rd), .IR_RD_VLD_o(i_vld)
    );

    ir_code_mem_arb #(.ADR_WIDTH(12), .BANK_ADR_WIDTH(9), .DAT_WIDTH(8)) u_dut_b (
        .CLK_i(clk), .RST_i(rst), .MODE_i(b_mode), .BUSY_i(b_busy),
        .HOST_WE_i(b_h_we), .HOST_RE_i(b_h_re), .HOST_ADR_i(b_h_adr), .HOST_WD_i(b_h_wd),
        .HOST_RD_o(b_h_rd), .HOST_RD_VLD_o(b_h_vld), .HOST_ERR_o(b_h_err), .HOST_ERR_CLR_i(b_h_clr),
        .IR_WE_i(b_i_we), .IR_RE_i(b_i_re), .IR_ADR_i(b_i_adr), .IR_WD_i(b_i_wd),
        .IR_RD_o(b_i_rd), .IR_RD_VLD_o(b_i_vld)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [10:0] adr, input logic [7:0] dat);
        h_we = 1'b1; h_adr = adr; h_wd = dat;
        step();
        h_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 1'b0; busy = 1'b0; h_we = 1'b0; h_re = 1'b0; h_clr = 1'b0;
        i_we = 1'b0; i_re = 1'b0; h_adr = '0; i_adr = '0; h_wd = '0; i_wd = '0;
        b_mode = 1'b0; b_busy = 1'b0; b_h_we = 1'b0; b_h_re = 1'b0; b_h_clr = 1'b0;
        b_i_we = 1'b0; b_i_re = 1'b0; b_h_adr = '0; b_i_adr = '0; b_h_wd = '0; b_i_wd = '0;
        step(); step();
        n_checks++;
        if ({h_rd, i_rd, h_vld, i_vld, h_err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state got hrd=%h ird=%h hv=%b iv=%b err=%b want all 0", h_rd, i_rd, h_vld, i_vld, h_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_host();
        host_wr(11'h005, 8'hA5);
        host_wr(11'h405, 8'h3C);
        h_re = 1'b1; h_adr = 11'h405;
        step();
        h_adr = 11'h005;
        step();
        h_re = 1'b0;
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'h3C) begin
            n_fail++;
            $display("FAIL idle_rd0 got vld=%b rd=%h want vld=1 rd=3c", h_vld, h_rd);
        end
        step();
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'hA5) begin
            n_fail++;
            $display("FAIL idle_rd1 got vld=%b rd=%h want vld=1 rd=a5", h_vld, h_rd);
        end
        step();
        n_checks++;
        if (h_vld !== 1'b0 || h_rd !== 8'hA5 || h_err !== 1'b0 || i_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got vld=%b rd=%h err=%b ivld=%b want 0 a5 0 0", h_vld, h_rd, h_err, i_vld);
        end
    endtask

    task automatic test_tx_own();
        mode = 1'b0; busy = 1'b1;
        i_re = 1'b1; i_adr = 11'h405;
        i_we = 1'b1; i_wd = 8'hFF;
        step();
        i_re = 1'b0; i_we = 1'b0;
        step();
        n_checks++;
        if (i_vld !== 1'b1 || i_rd !== 8'h3C || h_vld !== 1'b0 || h_rd !== 8'hA5) begin
            n_fail++;
            $display("FAIL tx_ir_read got ivld=%b ird=%h hvld=%b hrd=%h want 1 3c 0 a5", i_vld, i_rd, h_vld, h_rd);
        end
        h_re = 1'b1; h_adr = 11'h005;
        step();
        h_re = 1'b0;
        n_checks++;
        if (h_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_host_err got err=%b want 1", h_err);
        end
        step();
        n_checks++;
        if (h_vld !== 1'b0 || i_vld !== 1'b0 || h_rd !== 8'hA5) begin
            n_fail++;
            $display("FAIL tx_drop got hvld=%b ivld=%b hrd=%h want 0 0 a5", h_vld, i_vld, h_rd);
        end
        h_clr = 1'b1;
        step();
        h_clr = 1'b0;
        n_checks++;
        if (h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got err=%b want 0", h_err);
        end
        h_clr = 1'b1; h_re = 1'b1;
        step();
        h_clr = 1'b0; h_re = 1'b0;
        n_checks++;
        if (h_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins got err=%b want 1", h_err);
        end
        h_clr = 1'b1;
        step();
        h_clr = 1'b0;
        busy = 1'b0;
    endtask

    task automatic test_rx_own();
        mode = 1'b1; busy = 1'b1;
        i_we = 1'b1; i_adr = 11'h7FF; i_wd = 8'h77; i_re = 1'b1;
        h_we = 1'b1; h_adr = 11'h7FF; h_wd = 8'h99;
        step();
        i_we = 1'b0; i_re = 1'b0; h_we = 1'b0;
        n_checks++;
        if (h_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_host_we_err got err=%b want 1", h_err);
        end
        step();
        n_checks++;
        if (i_vld !== 1'b0 || h_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_ir_re_ignored got ivld=%b hvld=%b want 0 0", i_vld, h_vld);
        end
        h_clr = 1'b1; busy = 1'b0; mode = 1'b0;
        step();
        h_clr = 1'b0;
        h_re = 1'b1; h_adr = 11'h7FF;
        step();
        h_re = 1'b0;
        step();
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'h77 || h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_readback got vld=%b rd=%h err=%b want 1 77 0", h_vld, h_rd, h_err);
        end
    endtask

    task automatic test_own_change();
        h_re = 1'b1; h_adr = 11'h005;
        step();
        h_re = 1'b0; mode = 1'b0; busy = 1'b1;
        step();
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'hA5 || i_vld !== 1'b0 || i_rd !== 8'h3C) begin
            n_fail++;
            $display("FAIL own_change got hvld=%b hrd=%h ivld=%b ird=%h want 1 a5 0 3c", h_vld, h_rd, i_vld, i_rd);
        end
        busy = 1'b0;
        step();
    endtask

    task automatic test_read_first();
        host_wr(11'h010, 8'h22);
        mode = 1'b1; busy = 1'b1;
        i_we = 1'b1; i_adr = 11'h010; i_wd = 8'h11;
        h_re = 1'b1; h_adr = 11'h010;
        step();
        i_we = 1'b0; h_re = 1'b0;
        step();
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'h22 || h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_first_old got vld=%b rd=%h err=%b want 1 22 0", h_vld, h_rd, h_err);
        end
        busy = 1'b0; mode = 1'b0;
        h_re = 1'b1;
        step();
        h_re = 1'b0;
        step();
        n_checks++;
        if (h_vld !== 1'b1 || h_rd !== 8'h11) begin
            n_fail++;
            $display("FAIL read_first_new got vld=%b rd=%h want 1 11", h_vld, h_rd);
        end
    endtask

    task automatic test_reset_mid_read();
        h_re = 1'b1; h_adr = 11'h005;
        step();
        h_re = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({h_rd, i_rd, h_vld, i_vld, h_err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async got hrd=%h ird=%h hv=%b iv=%b err=%b want all 0", h_rd, i_rd, h_vld, i_vld, h_err);
        end
        step();
        rst = 1'b0;
        step(); step();
        n_checks++;
        if (h_vld !== 1'b0 || h_rd !== 8'h00 || i_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard got hvld=%b hrd=%h ivld=%b want 0 00 0", h_vld, h_rd, i_vld);
        end
    endtask

    task automatic test_eight_banks();
        for (int b = 0; b < 8; b++) begin
            b_h_we = 1'b1; b_h_adr = 12'(b << 9); b_h_wd = 8'(8'h50 + b);
            step();
        end
        b_h_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                n_checks++;
                if (b_h_vld !== 1'b1 || b_h_rd !== 8'(8'h50 + c - 2)) begin
                    n_fail++;
                    $display("FAIL bank8_rd%0d got vld=%b rd=%h want 1 %h", c - 2, b_h_vld, b_h_rd, 8'(8'h50 + c - 2));
                end
            end
            b_h_re = (c < 8);
            b_h_adr = 12'((c % 8) << 9);
            step();
        end
        b_h_re = 1'b0;
        b_mode = 1'b1; b_busy = 1'b1; b_h_we = 1'b1; b_h_adr = 12'h000; b_h_wd = 8'hEE;
        step();
        b_h_we = 1'b0; b_busy = 1'b0; b_mode = 1'b0;
        n_checks++;
        if (b_h_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bank8_err got err=%b want 1", b_h_err);
        end
        b_h_re = 1'b1;
        step();
        b_h_re = 1'b0;
        step();
        n_checks++;
        if (b_h_vld !== 1'b1 || b_h_rd !== 8'h50) begin
            n_fail++;
            $display("FAIL bank8_drop_wr got vld=%b rd=%h want 1 50", b_h_vld, b_h_rd);
        end
    endtask

    initial begin
        test_reset();
        test_idle_host();
        test_tx_own();
        test_rx_own();
        test_own_change();
        test_read_first();
        test_reset_mid_read();
        test_eight_banks();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
